pic16f84_fetch: RTL and testbench

- Instruction-fetch and program-counter stage, directly downstream of `pic16f84_clock`.
- Consumes the Q1/Q4 phase strobes and maintains the 13-bit PC, the program-memory address and the 8-level hardware return stack.
- Delivers one 14-bit instruction to the execute stage per instruction cycle.
- Executes branch, call, return, skip, PCL-write and interrupt redirects from execute, inserting a NOP bubble on every redirect (two-cycle branch, as in the PIC16F84).

---
 rtl/pic16f84_pkg.sv | 28 ++
 rtl/pic16f84_stack.sv | 54 +++++
 rtl/pic16f84_fetch.sv | 129 ++++++++++++
 tb/tb_pic16f84_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic16f84_pkg.sv
// Shared widths, vectors and redirect encoding for the PIC16F84 fetch stage.
package pic16f84_pkg;

  localparam int unsigned PC_W        = 13;
  localparam int unsigned IW          = 14;
  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned STK_W       = $clog2(STACK_DEPTH);
  localparam int unsigned LIT_W       = 11;
  localparam int unsigned PCLATH_W    = 5;
  localparam int unsigned PCL_W       = 8;

  localparam logic [PC_W-1:0] RESET_VECTOR = 13'h000;
  localparam logic [PC_W-1:0] INT_VECTOR   = 13'h004;
  localparam logic [IW-1:0]   NOP_INSTR    = 14'h0000;

  typedef enum logic [2:0] {
    REDIR_NONE,
    REDIR_RET,
    REDIR_CALL,
    REDIR_GOTO,
    REDIR_PCL
  } redir_e;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc_v);
    return pc_v + PC_W'(1);
  endfunction

endpackage

// File: rtl/pic16f84_stack.sv
// Circular 8-level return stack; overflow overwrites the oldest entry, underflow
// returns a stale entry. Simultaneous push/pop replaces the top in place.
module pic16f84_stack
  import pic16f84_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [PC_W-1:0]  data_i,
  output logic [PC_W-1:0]  top_o,
  output logic [STK_W-1:0] ptr_o
);

  logic [PC_W-1:0]  mem_q [STACK_DEPTH];
  logic [STK_W-1:0] ptr_q, ptr_d;
  logic [STK_W-1:0] top_idx;
  logic [STK_W-1:0] wr_idx;
  logic             wr_en;

  assign top_idx = ptr_q - STK_W'(1);
  assign top_o   = mem_q[top_idx];
  assign ptr_o   = ptr_q;

  always_comb begin : ptr_next
    ptr_d  = ptr_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en  = 1'b1;
      ptr_d  = ptr_q + STK_W'(1);
    end else if (pop_i) begin
      ptr_d  = top_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stack_regs
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (wr_en) begin
        mem_q[wr_idx] <= data_i;
      end
    end
  end

endmodule

// File: rtl/pic16f84_fetch.sv
// PIC16F84 fetch/PC stage: fetches at Q4, loads IR at Q1, and applies
// branch/call/return/skip/PCL/interrupt redirects with a one-cycle NOP bubble.
module pic16f84_fetch
  import pic16f84_pkg::*;
(
  input  logic                clk,
  input  logic                mclr,
  input  logic                q1,
  input  logic                q4,
  output logic [PC_W-1:0]     pm_addr,
  input  logic [IW-1:0]       pm_data,
  input  logic                br_goto,
  input  logic                br_call,
  input  logic                br_ret,
  input  logic                br_skip,
  input  logic [LIT_W-1:0]    br_addr,
  input  logic [PCLATH_W-1:0] pclath,
  input  logic                pcl_wr,
  input  logic [PCL_W-1:0]    pcl_data,
  input  logic                int_req,
  output logic [IW-1:0]       ir,
  output logic                ir_valid,
  output logic [PC_W-1:0]     pc,
  output logic                flush,
  output logic [STK_W-1:0]    stk_ptr
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [IW-1:0]   fb_q, fb_d;
  logic            ir_valid_q, ir_valid_d;
  logic            flush_q, flush_d;
  logic            fb_valid_q, fb_valid_d;

  logic            q1_step, q4_step;
  redir_e          redir;
  logic [PC_W-1:0] redir_tgt;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] push_data;
  logic            push, pop;

  // Coincident strobes are illegal from the clock stage; treat them as a hold.
  assign q1_step = q1 & ~q4;
  assign q4_step = q4 & ~q1;

  assign pm_addr  = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign flush    = flush_q;

  always_comb begin : redirect_select
    redir = REDIR_NONE;
    if (br_ret) begin
      redir = REDIR_RET;
    end else if (br_call) begin
      redir = REDIR_CALL;
    end else if (br_goto) begin
      redir = REDIR_GOTO;
    end else if (pcl_wr) begin
      redir = REDIR_PCL;
    end
  end

  // Target pc would take without an interrupt; also the interrupt's return address.
  always_comb begin : target_mux
    redir_tgt = pc_inc(pc_q);
    case (redir)
      REDIR_RET:              redir_tgt = stk_top;
      REDIR_CALL, REDIR_GOTO: redir_tgt = {pclath[4:3], br_addr};
      REDIR_PCL:              redir_tgt = {pclath, pcl_data};
      default:                redir_tgt = pc_inc(pc_q);
    endcase
  end

  assign pop       = q4_step & (redir == REDIR_RET);
  assign push      = q4_step & (int_req | (redir == REDIR_CALL));
  assign push_data = int_req ? redir_tgt : pc_q;

  always_comb begin : next_state
    pc_d       = pc_q;
    fb_d       = fb_q;
    fb_valid_d = fb_valid_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    flush_d    = flush_q;
    if (q4_step) begin
      fb_d       = pm_data;
      fb_valid_d = (redir == REDIR_NONE) & ~br_skip & ~int_req;
      pc_d       = int_req ? INT_VECTOR : redir_tgt;
    end
    if (q1_step) begin
      ir_d       = fb_valid_q ? fb_q : NOP_INSTR;
      ir_valid_d = fb_valid_q;
      flush_d    = ~fb_valid_q;
    end
  end

  always_ff @(posedge clk or negedge mclr) begin : fetch_regs
    if (!mclr) begin
      pc_q       <= RESET_VECTOR;
      fb_q       <= NOP_INSTR;
      fb_valid_q <= 1'b0;
      ir_q       <= NOP_INSTR;
      ir_valid_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fb_q       <= fb_d;
      fb_valid_q <= fb_valid_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      flush_q    <= flush_d;
    end
  end

  pic16f84_stack u_stack (
    .clk    (clk),
    .rst_n  (mclr),
    .push_i (push),
    .pop_i  (pop),
    .data_i (push_data),
    .top_o  (stk_top),
    .ptr_o  (stk_ptr)
  );

  a_q1_q4_exclusive: assert property (@(posedge clk) disable iff (!mclr) !(q1 && q4));

endmodule

// File: tb/tb_pic16f84_fetch.sv
// Self-checking bench for pic16f84_fetch: drives Q1..Q4 phases and execute-stage
// redirects, and compares IR/PC/stack pointer against a queued reference model.
module tb_pic16f84_fetch;
  import pic16f84_pkg::*;

  localparam int OP_NONE = 0;
  localparam int OP_GOTO = 1;
  localparam int OP_CALL = 2;
  localparam int OP_RET  = 3;
  localparam int OP_SKIP = 4;
  localparam int OP_PCLW = 5;

  typedef struct packed {
    logic [IW-1:0] ir;
    logic          valid;
    logic          flush;
  } q1_exp_t;

  logic                clk = 1'b0;
  logic                mclr = 1'b0;
  logic                q1 = 1'b0;
  logic                q4 = 1'b0;
  logic [PC_W-1:0]     pm_addr;
  logic [IW-1:0]       pm_data;
  logic                br_goto = 1'b0;
  logic                br_call = 1'b0;
  logic                br_ret = 1'b0;
  logic                br_skip = 1'b0;
  logic [LIT_W-1:0]    br_addr = '0;
  logic [PCLATH_W-1:0] pclath = '0;
  logic                pcl_wr = 1'b0;
  logic [PCL_W-1:0]    pcl_data = '0;
  logic                int_req = 1'b0;
  logic [IW-1:0]       ir;
  logic                ir_valid;
  logic [PC_W-1:0]     pc;
  logic                flush;
  logic [STK_W-1:0]    stk_ptr;

  int n_cmp = 0;
  int n_err = 0;

  logic [PC_W-1:0]  m_pc;
  logic [PC_W-1:0]  m_stk [STACK_DEPTH];
  logic [STK_W-1:0] m_ptr;
  q1_exp_t          exp_q [$];
  logic [PC_W-1:0]  ret9;
  logic [PC_W-1:0]  call_ret;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] word_at(input logic [PC_W-1:0] a);
    return IW'(32'h3000 + 32'(a));
  endfunction

  assign pm_data = word_at(pm_addr);

  pic16f84_fetch dut (
    .clk      (clk),
    .mclr     (mclr),
    .q1       (q1),
    .q4       (q4),
    .pm_addr  (pm_addr),
    .pm_data  (pm_data),
    .br_goto  (br_goto),
    .br_call  (br_call),
    .br_ret   (br_ret),
    .br_skip  (br_skip),
    .br_addr  (br_addr),
    .pclath   (pclath),
    .pcl_wr   (pcl_wr),
    .pcl_data (pcl_data),
    .int_req  (int_req),
    .ir       (ir),
    .ir_valid (ir_valid),
    .pc       (pc),
    .flush    (flush),
    .stk_ptr  (stk_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RESET_VECTOR;
    m_ptr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) m_stk[i] = '0;
    exp_q.delete();
    exp_q.push_back('{NOP_INSTR, 1'b0, 1'b1});
  endtask

  task automatic clear_exec();
    br_goto = 1'b0; br_call = 1'b0; br_ret = 1'b0; br_skip = 1'b0;
    br_addr = '0; pclath = '0; pcl_wr = 1'b0; pcl_data = '0; int_req = 1'b0;
  endtask

  task automatic q1_phase();
    q1_exp_t e;
    @(negedge clk);
    q1 = 1'b1; q4 = 1'b0;
    clear_exec();
    @(posedge clk); #1;
    chk("q1_queue_depth", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ir", 32'(ir), 32'(e.ir));
      chk("ir_valid", 32'(ir_valid), 32'(e.valid));
      chk("flush", 32'(flush), 32'(e.flush));
    end
  endtask

  task automatic q23_phase();
    @(negedge clk);
    q1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic q4_phase(input int op, input logic [LIT_W-1:0] addr,
                          input logic [PCLATH_W-1:0] lath, input logic [PCL_W-1:0] pdat,
                          input logic intr);
    logic [PC_W-1:0] nxt;
    logic            kill;
    @(negedge clk);
    q4 = 1'b1;
    br_goto = (op == OP_GOTO); br_call = (op == OP_CALL); br_ret = (op == OP_RET);
    br_skip = (op == OP_SKIP); pcl_wr = (op == OP_PCLW);
    br_addr = addr; pclath = lath; pcl_data = pdat; int_req = intr;
    #1;
    chk("pm_addr", 32'(pm_addr), 32'(m_pc));
    nxt  = PC_W'(m_pc + 1);
    kill = 1'b0;
    case (op)
      OP_RET: begin
        m_ptr = STK_W'(m_ptr - 1);
        nxt   = m_stk[m_ptr];
        kill  = 1'b1;
      end
      OP_CALL: begin
        if (!intr) begin
          m_stk[m_ptr] = m_pc;
          m_ptr = STK_W'(m_ptr + 1);
        end
        nxt  = {lath[4:3], addr};
        kill = 1'b1;
      end
      OP_GOTO: begin nxt = {lath[4:3], addr}; kill = 1'b1; end
      OP_PCLW: begin nxt = {lath, pdat}; kill = 1'b1; end
      OP_SKIP: kill = 1'b1;
      default: ;
    endcase
    if (intr) begin
      m_stk[m_ptr] = nxt;
      m_ptr = STK_W'(m_ptr + 1);
      nxt   = INT_VECTOR;
      kill  = 1'b1;
    end
    if (kill) exp_q.push_back('{NOP_INSTR, 1'b0, 1'b1});
    else      exp_q.push_back('{word_at(m_pc), 1'b1, 1'b0});
    m_pc = nxt;
    @(posedge clk); #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("stk_ptr", 32'(stk_ptr), 32'(m_ptr));
  endtask

  task automatic exec(input int op, input logic [LIT_W-1:0] addr,
                      input logic [PCLATH_W-1:0] lath, input logic [PCL_W-1:0] pdat,
                      input logic intr);
    q1_phase();
    q23_phase();
    q4_phase(op, addr, lath, pdat, intr);
  endtask

  task automatic nop_cycle();
    exec(OP_NONE, '0, '0, '0, 1'b0);
  endtask

  initial begin
    clear_exec();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_stk_ptr", 32'(stk_ptr), 32'h0);
    model_reset();
    @(negedge clk);
    mclr = 1'b1;

    // Sequential fetch from the reset vector.
    nop_cycle();
    chk("first_fetch_pc", 32'(pc), 32'h001);
    repeat (3) nop_cycle();
    chk("seq_pc", 32'(pc), 32'h004);
    chk("seq_ir", 32'(ir), 32'h3002);

    // GOTO with PCLATH page bits.
    exec(OP_GOTO, 11'h123, 5'h18, '0, 1'b0);
    chk("goto_pc", 32'(pc), 32'h1923);
    nop_cycle();
    chk("goto_bubble_flush", 32'(flush), 32'h1);
    nop_cycle();
    chk("goto_target_ir", 32'(ir), 32'(word_at(13'h1923)));

    // CALL from 0x010 to 0x200 and RETURN.
    exec(OP_GOTO, 11'h010, 5'h00, '0, 1'b0);
    nop_cycle();
    exec(OP_CALL, 11'h200, 5'h00, '0, 1'b0);
    chk("call_pc", 32'(pc), 32'h200);
    chk("call_stk", 32'(stk_ptr), 32'h1);
    nop_cycle();
    nop_cycle();
    exec(OP_RET, '0, '0, '0, 1'b0);
    chk("ret_pc", 32'(pc), 32'h011);
    chk("ret_stk", 32'(stk_ptr), 32'h0);
    nop_cycle();
    nop_cycle();
    chk("ret_resume_ir", 32'(ir), 32'(word_at(13'h011)));

    // Nine nested CALLs overflow the circular stack.
    ret9 = '0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) ret9 = m_pc;
      exec(OP_CALL, LIT_W'(12'h100 + 12'(i * 16)), 5'h00, '0, 1'b0);
      nop_cycle();
    end
    chk("ovf_stk", 32'(stk_ptr), 32'h1);
    for (int i = 0; i < 9; i++) begin
      exec(OP_RET, '0, '0, '0, 1'b0);
      if (i == 0) chk("ovf_ret_first", 32'(pc), 32'(ret9));
      if (i == 8) chk("ovf_ret_ninth", 32'(pc), 32'(ret9));
      nop_cycle();
    end
    chk("ovf_stk_end", 32'(stk_ptr), 32'h0);

    // Interrupt coincident with GOTO pushes the GOTO target.
    exec(OP_GOTO, 11'h050, 5'h00, '0, 1'b1);
    chk("int_pc", 32'(pc), 32'h004);
    chk("int_stk", 32'(stk_ptr), 32'h1);
    nop_cycle();
    exec(OP_RET, '0, '0, '0, 1'b0);
    chk("retfie_pc", 32'(pc), 32'h050);
    nop_cycle();

    // Skip, PCL write, and interrupt coincident with RETURN.
    nop_cycle();
    exec(OP_SKIP, '0, '0, '0, 1'b0);
    nop_cycle();
    exec(OP_PCLW, '0, 5'h02, 8'h34, 1'b0);
    chk("pclw_pc", 32'(pc), 32'h234);
    nop_cycle();
    call_ret = m_pc;
    exec(OP_CALL, 11'h300, 5'h00, '0, 1'b0);
    nop_cycle();
    exec(OP_RET, '0, '0, '0, 1'b1);
    chk("int_ret_pc", 32'(pc), 32'h004);
    chk("int_ret_stk", 32'(stk_ptr), 32'h1);
    exec(OP_RET, '0, '0, '0, 1'b0);
    chk("int_ret_back", 32'(pc), 32'(call_ret));
    nop_cycle();

    // PC wraps from the top of program memory.
    exec(OP_GOTO, 11'h7FF, 5'h18, '0, 1'b0);
    chk("wrap_top_pc", 32'(pc), 32'h1FFF);
    nop_cycle();
    chk("wrap_pc", 32'(pc), 32'h0000);
    nop_cycle();

    // Asynchronous reset in mid-cycle after a CALL.
    exec(OP_CALL, 11'h0AA, 5'h00, '0, 1'b0);
    q1_phase();
    @(negedge clk);
    q1 = 1'b0;
    #2;
    mclr = 1'b0;
    #1;
    chk("mrst_pc", 32'(pc), 32'h0);
    chk("mrst_stk", 32'(stk_ptr), 32'h0);
    chk("mrst_ir", 32'(ir), 32'h0);
    chk("mrst_ir_valid", 32'(ir_valid), 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    mclr = 1'b1;
    nop_cycle();
    nop_cycle();
    chk("mrst_restart_ir", 32'(ir), 32'h3000);
    nop_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
